// File: rtl/dual_issue_hazard_ctrl.sv
// Dual-pipe REG->EX issue controller with a per-register latency scoreboard (RAW/WAW checks, pair split).
// Optional macro HAZARD_FORWARD_EN: a consumer may issue while its producer is in the final latency cycle.
module dual_issue_hazard_ctrl #(
  parameter int NUM_REGS   = 128,
  parameter int REG_ADDR_W = 7,
  parameter int LAT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid_REG1,
  input  logic                  valid_REG2,
  input  logic                  regWriteEnable_REG1,
  input  logic                  regWriteEnable_REG2,
  input  logic [REG_ADDR_W-1:0] rt_REG1,
  input  logic [REG_ADDR_W-1:0] rt_REG2,
  input  logic                  useRA_REG1,
  input  logic                  useRB_REG1,
  input  logic                  useRC_REG1,
  input  logic                  useRA_REG2,
  input  logic                  useRB_REG2,
  input  logic                  useRC_REG2,
  input  logic [REG_ADDR_W-1:0] readRegisterRA_REG1,
  input  logic [REG_ADDR_W-1:0] readRegisterRB_REG1,
  input  logic [REG_ADDR_W-1:0] readRegisterRC_REG1,
  input  logic [REG_ADDR_W-1:0] readRegisterRA_REG2,
  input  logic [REG_ADDR_W-1:0] readRegisterRB_REG2,
  input  logic [REG_ADDR_W-1:0] readRegisterRC_REG2,
  input  logic [LAT_W-1:0]      latency_REG1,
  input  logic [LAT_W-1:0]      latency_REG2,
  output logic                  issue_EX1,
  output logic                  issue_EX2,
  output logic                  stall_REG,
  output logic [PERF_W-1:0]     stall_count
);

`ifdef HAZARD_FORWARD_EN
  localparam logic [LAT_W-1:0] RDY_TH = LAT_W'(1);
`else
  localparam logic [LAT_W-1:0] RDY_TH = '0;
`endif

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_SPLIT  = 1'b1;

  logic [LAT_W-1:0]  cnt_q [NUM_REGS];
  logic [LAT_W-1:0]  cnt_d [NUM_REGS];
  logic [0:0]        state_q, state_d;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  logic srcOk1, srcOk2, haz1, haz2, pairDep;
  logic iss1, iss2, stall;

  assign srcOk1 = (!useRA_REG1 || (cnt_q[readRegisterRA_REG1] <= RDY_TH))
               && (!useRB_REG1 || (cnt_q[readRegisterRB_REG1] <= RDY_TH))
               && (!useRC_REG1 || (cnt_q[readRegisterRC_REG1] <= RDY_TH));
  assign srcOk2 = (!useRA_REG2 || (cnt_q[readRegisterRA_REG2] <= RDY_TH))
               && (!useRB_REG2 || (cnt_q[readRegisterRB_REG2] <= RDY_TH))
               && (!useRC_REG2 || (cnt_q[readRegisterRC_REG2] <= RDY_TH));

  // A writer may not retire before an older in-flight write to the same register.
  assign haz1 = valid_REG1 && (!srcOk1 ||
                (regWriteEnable_REG1 && (cnt_q[rt_REG1] > latency_REG1)));
  assign haz2 = valid_REG2 && (!srcOk2 ||
                (regWriteEnable_REG2 && (cnt_q[rt_REG2] > latency_REG2)));

  assign pairDep = valid_REG1 && regWriteEnable_REG1 &&
                   ((useRA_REG2 && (readRegisterRA_REG2 == rt_REG1)) ||
                    (useRB_REG2 && (readRegisterRB_REG2 == rt_REG1)) ||
                    (useRC_REG2 && (readRegisterRC_REG2 == rt_REG1)) ||
                    (regWriteEnable_REG2 && (rt_REG2 == rt_REG1)));

  always_comb begin
    state_d = state_q;
    iss1    = 1'b0;
    iss2    = 1'b0;
    stall   = 1'b0;
    if (state_q == ST_NORMAL) begin
      if (flush) begin
        state_d = ST_NORMAL;
      end else if (haz1) begin
        stall = 1'b1;
      end else if (!valid_REG1) begin
        if (haz2) begin
          stall = 1'b1;
        end else begin
          iss2 = valid_REG2;
        end
      end else if (valid_REG2 && (haz2 || pairDep)) begin
        iss1    = 1'b1;
        stall   = 1'b1;
        state_d = ST_SPLIT;
      end else begin
        iss1 = 1'b1;
        iss2 = valid_REG2;
      end
    end else begin
      // Slot1 already left for EX; only slot2 remains to be judged.
      if (flush) begin
        state_d = ST_NORMAL;
      end else if (haz2) begin
        stall = 1'b1;
      end else begin
        iss2    = valid_REG2;
        state_d = ST_NORMAL;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
    end
    if (iss1 && regWriteEnable_REG1 && (latency_REG1 != '0)) begin
      cnt_d[rt_REG1] = (latency_REG1 > cnt_d[rt_REG1]) ? latency_REG1 : cnt_d[rt_REG1];
    end
    if (iss2 && regWriteEnable_REG2 && (latency_REG2 != '0)) begin
      cnt_d[rt_REG2] = (latency_REG2 > cnt_d[rt_REG2]) ? latency_REG2 : cnt_d[rt_REG2];
    end
  end

  assign stall_count_d = (stall && (stall_count_q != '1)) ? (stall_count_q + PERF_W'(1))
                                                          : stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      state_q       <= ST_NORMAL;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign issue_EX1   = reset && iss1;
  assign issue_EX2   = reset && iss2;
  assign stall_REG   = reset && stall;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Bench for dual_issue_hazard_ctrl: directed instruction pairs, a ready-time scoreboard model checked
// every cycle, and hand-computed literal expectations. Define HAZARD_FORWARD_EN to check that variant.
`timescale 1ns/1ps
module tb_dual_issue_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  localparam int NONE = -1;

  typedef struct {
    logic       valid;
    logic       we;
    logic [6:0] rt;
    logic [2:0] lat;
    logic       useA, useB, useC;
    logic [6:0] ra, rb, rc;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  slot_t       s1, s2;
  logic        issue_EX1, issue_EX2, stall_REG;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_issue_hazard_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .valid_REG1          (s1.valid),
    .valid_REG2          (s2.valid),
    .regWriteEnable_REG1 (s1.we),
    .regWriteEnable_REG2 (s2.we),
    .rt_REG1             (s1.rt),
    .rt_REG2             (s2.rt),
    .useRA_REG1          (s1.useA),
    .useRB_REG1          (s1.useB),
    .useRC_REG1          (s1.useC),
    .useRA_REG2          (s2.useA),
    .useRB_REG2          (s2.useB),
    .useRC_REG2          (s2.useC),
    .readRegisterRA_REG1 (s1.ra),
    .readRegisterRB_REG1 (s1.rb),
    .readRegisterRC_REG1 (s1.rc),
    .readRegisterRA_REG2 (s2.ra),
    .readRegisterRB_REG2 (s2.rb),
    .readRegisterRC_REG2 (s2.rc),
    .latency_REG1        (s1.lat),
    .latency_REG2        (s2.lat),
    .issue_EX1           (issue_EX1),
    .issue_EX2           (issue_EX2),
    .stall_REG           (stall_REG),
    .stall_count         (stall_count)
  );

  // Build a valid slot; a negative register number means "not written" / "not read".
  function automatic slot_t mkSlot(int rt, int lat, int ra, int rb, int rc);
    slot_t s;
    s.valid = 1'b1;
    s.we    = (rt >= 0);
    s.rt    = (rt >= 0) ? 7'(rt) : 7'd0;
    s.lat   = 3'(lat);
    s.useA  = (ra >= 0);
    s.ra    = (ra >= 0) ? 7'(ra) : 7'd0;
    s.useB  = (rb >= 0);
    s.rb    = (rb >= 0) ? 7'(rb) : 7'd0;
    s.useC  = (rc >= 0);
    s.rc    = (rc >= 0) ? 7'(rc) : 7'd0;
    return s;
  endfunction

  function automatic slot_t emptySlot();
    slot_t s;
    s = mkSlot(NONE, 0, NONE, NONE, NONE);
    s.valid = 1'b0;
    return s;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(slot_t a, slot_t b, logic fl);
    s1    = a;
    s2    = b;
    flush = fl;
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle's outputs and moves to the next cycle.
  task automatic cycleExpect(string tag, logic x1, logic x2, logic xs);
    @(negedge clk);
    checkOutput({tag, ".issue1"}, int'(issue_EX1), int'(x1));
    checkOutput({tag, ".issue2"}, int'(issue_EX2), int'(x2));
    checkOutput({tag, ".stall"},  int'(stall_REG), int'(xs));
    @(posedge clk);
    #1;
  endtask

  // Model: each register remembers the absolute cycle at which its pending write is complete;
  // the pipe pair is described by whether slot1 has already gone ahead of slot2.
  int readyAt [128];
  int mdlNow   = 0;
  bit mdlDone1 = 1'b0;
  int mdlStall = 0;

  function automatic int remaining(logic [6:0] r);
    int d;
    d = readyAt[r] - mdlNow;
    return (d > 0) ? d : 0;
  endfunction

  function automatic bit blocked(slot_t s);
    bit w;
    w = (s.useA && remaining(s.ra) > FWD) || (s.useB && remaining(s.rb) > FWD) ||
        (s.useC && remaining(s.rc) > FWD) || (s.we && remaining(s.rt) > int'(s.lat));
    return s.valid && w;
  endfunction

  function automatic bit dependsOn(slot_t older, slot_t younger);
    bit d;
    d = (younger.useA && younger.ra == older.rt) || (younger.useB && younger.rb == older.rt) ||
        (younger.useC && younger.rc == older.rt) || (younger.we && younger.rt == older.rt);
    return older.valid && older.we && d;
  endfunction

  initial begin : compare
    bit go1, go2, expStall, nextDone1, pending1;
    int newReady1, newReady2;
    forever begin
      @(negedge clk);
      go1 = 1'b0;
      go2 = 1'b0;
      expStall  = 1'b0;
      nextDone1 = 1'b0;
      if (!reset) begin
        for (int r = 0; r < 128; r++) readyAt[r] = 0;
        mdlNow   = 0;
        mdlDone1 = 1'b0;
        mdlStall = 0;
      end else begin
        pending1 = s1.valid && !mdlDone1;
        if (!flush) begin
          if (pending1) begin
            if (!blocked(s1)) begin
              go1 = 1'b1;
              go2 = s2.valid && !blocked(s2) && !dependsOn(s1, s2);
            end
          end else begin
            go2 = s2.valid && !blocked(s2);
          end
          expStall  = (pending1 && !go1) || (s2.valid && !go2);
          nextDone1 = (mdlDone1 || go1) && s2.valid && !go2;
        end
      end
      checkOutput("model.issue1", int'(issue_EX1), int'(go1));
      checkOutput("model.issue2", int'(issue_EX2), int'(go2));
      checkOutput("model.stall",  int'(stall_REG), int'(expStall));
      checkOutput("model.stall_count", int'(stall_count), mdlStall);
      newReady1 = mdlNow + 1 + int'(s1.lat);
      newReady2 = mdlNow + 1 + int'(s2.lat);
      @(posedge clk);
      if (reset) begin
        if (go1 && s1.we && s1.lat != 0 && newReady1 > readyAt[s1.rt]) readyAt[s1.rt] = newReady1;
        if (go2 && s2.we && s2.lat != 0 && newReady2 > readyAt[s2.rt]) readyAt[s2.rt] = newReady2;
        mdlNow++;
        mdlDone1 = nextDone1;
        if (expStall && mdlStall < 65535) mdlStall++;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    // Reset with a valid independent pair present: everything must stay quiet.
    applyStimulus(mkSlot(1, 2, 2, NONE, NONE), mkSlot(4, 2, 6, NONE, NONE), 1'b0);
    @(negedge clk);
    checkOutput("reset.issue1", int'(issue_EX1), 0);
    checkOutput("reset.issue2", int'(issue_EX2), 0);
    checkOutput("reset.stall",  int'(stall_REG), 0);
    checkOutput("reset.stall_count", int'(stall_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Independent pair issues together; the consumers then wait on cnt[1]=cnt[4]=2.
    applyStimulus(mkSlot(1, 2, 2, 3, NONE), mkSlot(4, 2, 6, 7, NONE), 1'b0);
    cycleExpect("indep", 1'b1, 1'b1, 1'b0);
    applyStimulus(mkSlot(NONE, 0, 1, NONE, NONE), mkSlot(NONE, 0, 4, NONE, NONE), 1'b0);
    for (int i = 0; i < 2 - FWD; i++) cycleExpect("indepUse.wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("indepUse.go", 1'b1, 1'b1, 1'b0);
    checkOutput("count.indep", int'(stall_count), 2 - FWD);

    // Slot2 reads r10 written by slot1 (L=6): split; cnt[10]=6 in the first SPLIT cycle.
    applyStimulus(mkSlot(10, 6, NONE, NONE, NONE), mkSlot(11, 1, NONE, NONE, 10), 1'b0);
    cycleExpect("dep.split", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6 - FWD; i++) cycleExpect("dep.wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("dep.go2", 1'b0, 1'b1, 1'b0);
    checkOutput("count.dep", int'(stall_count), 9 - 2 * FWD);

    // cnt[20]=3, then slot1 reads r20.
    applyStimulus(mkSlot(20, 3, NONE, NONE, NONE), emptySlot(), 1'b0);
    cycleExpect("w20", 1'b1, 1'b0, 1'b0);
    applyStimulus(mkSlot(NONE, 0, 20, NONE, NONE), emptySlot(), 1'b0);
    for (int i = 0; i < 3 - FWD; i++) cycleExpect("r20.wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("r20.go", 1'b1, 1'b0, 1'b0);
    checkOutput("count.r20", int'(stall_count), 12 - 3 * FWD);

    // Both write r8: serialised, then a lone slot2 reads r8 (cnt[8]=2).
    applyStimulus(mkSlot(8, 2, NONE, NONE, NONE), mkSlot(8, 2, NONE, NONE, NONE), 1'b0);
    cycleExpect("waw8.first", 1'b1, 1'b0, 1'b1);
    cycleExpect("waw8.second", 1'b0, 1'b1, 1'b0);
    applyStimulus(emptySlot(), mkSlot(NONE, 0, NONE, 8, NONE), 1'b0);
    for (int i = 0; i < 2 - FWD; i++) cycleExpect("alone2.wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("alone2.go", 1'b0, 1'b1, 1'b0);

    // Write-order rule: a short-latency write to r9 waits until cnt[9] <= 2.
    applyStimulus(mkSlot(9, 5, NONE, NONE, NONE), emptySlot(), 1'b0);
    cycleExpect("w9.long", 1'b1, 1'b0, 1'b0);
    applyStimulus(mkSlot(9, 2, NONE, NONE, NONE), emptySlot(), 1'b0);
    for (int i = 0; i < 3; i++) cycleExpect("w9.wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("w9.short", 1'b1, 1'b0, 1'b0);
    checkOutput("count.waw", int'(stall_count), 18 - 4 * FWD);

    // Flush in NORMAL discards the pair without stalling.
    applyStimulus(mkSlot(40, 1, 41, NONE, NONE), mkSlot(42, 1, 43, NONE, NONE), 1'b1);
    cycleExpect("flushN", 1'b0, 1'b0, 1'b0);
    applyStimulus(mkSlot(40, 1, 41, NONE, NONE), mkSlot(42, 1, 43, NONE, NONE), 1'b0);
    cycleExpect("afterFlushN", 1'b1, 1'b1, 1'b0);

    // Flush in SPLIT drops slot2; cnt[12] keeps draining (3 left when slot1 reads it).
    applyStimulus(mkSlot(12, 5, NONE, NONE, NONE), mkSlot(NONE, 0, 12, NONE, NONE), 1'b0);
    cycleExpect("flushS.split", 1'b1, 1'b0, 1'b1);
    cycleExpect("flushS.wait", 1'b0, 1'b0, 1'b1);
    applyStimulus(mkSlot(12, 5, NONE, NONE, NONE), mkSlot(NONE, 0, 12, NONE, NONE), 1'b1);
    cycleExpect("flushS.flush", 1'b0, 1'b0, 1'b0);
    applyStimulus(mkSlot(NONE, 0, 12, NONE, NONE), emptySlot(), 1'b0);
    for (int i = 0; i < 3 - FWD; i++) cycleExpect("flushS.r12wait", 1'b0, 1'b0, 1'b1);
    cycleExpect("flushS.r12go", 1'b1, 1'b0, 1'b0);
    checkOutput("count.flushS", int'(stall_count), 23 - 5 * FWD);

    // Reset while SPLIT with cnt[5]=4.
    applyStimulus(mkSlot(5, 5, NONE, NONE, NONE), mkSlot(NONE, 0, 5, NONE, NONE), 1'b0);
    cycleExpect("rst.split", 1'b1, 1'b0, 1'b1);
    cycleExpect("rst.wait", 1'b0, 1'b0, 1'b1);
    checkOutput("count.preReset", int'(stall_count), 25 - 5 * FWD);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst.issue1", int'(issue_EX1), 0);
    checkOutput("rst.issue2", int'(issue_EX2), 0);
    checkOutput("rst.stall",  int'(stall_REG), 0);
    checkOutput("rst.stall_count", int'(stall_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(mkSlot(6, 1, 5, NONE, NONE), mkSlot(7, 1, 5, NONE, NONE), 1'b0);
    cycleExpect("rst.after", 1'b1, 1'b1, 1'b0);
    checkOutput("count.postReset", int'(stall_count), 0);

    // Ping-pong pair keeps the REG stage stalled almost every cycle until the counter saturates.
    applyStimulus(mkSlot(30, 7, 31, NONE, NONE), mkSlot(31, 7, 30, NONE, NONE), 1'b0);
    for (int i = 0; i < 80000 && mdlStall < 65535; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("sat.reached", mdlStall, 65535);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("sat.hold", int'(stall_count), 16'hFFFF);

    applyStimulus(emptySlot(), emptySlot(), 1'b0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
